// File: rtl/eq_pkg.sv
// Shared types and constants for the five-band stereo equalizer FIR scheduler.
// Band ids, tap/address widths, scheduler FSM states, default buffer mask.
package eq_pkg;

  localparam int N_BANDS = 5;
  localparam int TAP_W   = 10;
  localparam int CA_W    = 3 + TAP_W;

  localparam logic [N_BANDS-1:0] HI_MASK_DEF = 5'b11000;

  typedef enum logic [2:0] {
    BAND_LP = 3'd0,
    BAND_B1 = 3'd1,
    BAND_B2 = 3'd2,
    BAND_B3 = 3'd3,
    BAND_HP = 3'd4
  } band_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_NEXT  = 3'd4
  } state_e;

endpackage

// File: rtl/eq_lat_pipe.sv
// DEPTH-deep 1-bit delay line with synchronous active-high reset.
// Ports: clk, rst, d (input bit), q (d delayed by DEPTH cycles).
module eq_lat_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++)
        sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/eq_fir_scheduler.sv
// Sequences one shared stereo MAC over five FIR bands per sample frame.
// Ports: clk, rst, valid, lo_full, hi_full in; tap/ROM addresses, MAC control, status out.
module eq_fir_scheduler
  import eq_pkg::*;
#(
  parameter int                 N_TAPS  = 1021,
  parameter int                 RD_LAT  = 2,
  parameter logic [N_BANDS-1:0] HI_MASK = HI_MASK_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic            lo_full,
  input  logic            hi_full,
  output logic [TAP_W-1:0] tap_idx,
  output logic [CA_W-1:0] coeff_addr,
  output logic            addr_vld,
  output logic            buf_sel,
  output logic            mac_clr,
  output logic            mac_en,
  output logic            band_done,
  output logic [2:0]      band_id,
  output logic            frame_done,
  output logic            busy,
  output logic            overrun,
  output logic            amp_on
);

  state_e     state;
  logic [3:0] dcnt;
  logic       start;
  logic       last;
  logic       both_full;
  logic       tap_end;
  logic       drain_end;
  logic [2:0] nb;

  assign both_full = lo_full & hi_full;
  assign start     = valid & both_full;
  assign last      = (band_id == 3'(N_BANDS - 1));
  assign tap_end   = (tap_idx == TAP_W'(N_TAPS - 1));
  assign drain_end = (dcnt == 4'(RD_LAT - 1));
  assign nb        = band_id + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      band_id    <= 3'd0;
      tap_idx    <= '0;
      dcnt       <= 4'd0;
      addr_vld   <= 1'b0;
      buf_sel    <= 1'b0;
      mac_clr    <= 1'b0;
      band_done  <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      amp_on     <= 1'b0;
    end else begin
      mac_clr    <= 1'b0;
      band_done  <= 1'b0;
      frame_done <= 1'b0;

      // A valid is only legal when idle or on the final band's NEXT cycle.
      if (valid && state != S_IDLE && !(state == S_NEXT && last))
        overrun <= 1'b1;

      // Amp drops as soon as a buffer loses prime; it re-arms at frame end.
      if (!both_full)
        amp_on <= 1'b0;
      else if (state == S_DRAIN && drain_end && last)
        amp_on <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_CLR;
            band_id <= BAND_LP;
            tap_idx <= '0;
            mac_clr <= 1'b1;
            buf_sel <= HI_MASK[BAND_LP];
          end
        end
        S_CLR: begin
          state    <= S_RUN;
          addr_vld <= 1'b1;
        end
        S_RUN: begin
          if (tap_end) begin
            state    <= S_DRAIN;
            addr_vld <= 1'b0;
            dcnt     <= 4'd0;
          end else begin
            tap_idx <= tap_idx + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_end) begin
            state      <= S_NEXT;
            band_done  <= 1'b1;
            frame_done <= last;
          end else begin
            dcnt <= dcnt + 4'd1;
          end
        end
        S_NEXT: begin
          if (last) begin
            if (start) begin
              state   <= S_CLR;
              band_id <= BAND_LP;
              tap_idx <= '0;
              mac_clr <= 1'b1;
              buf_sel <= HI_MASK[BAND_LP];
            end else begin
              state <= S_IDLE;
            end
          end else begin
            state   <= S_CLR;
            band_id <= nb;
            tap_idx <= '0;
            mac_clr <= 1'b1;
            buf_sel <= HI_MASK[nb];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  eq_lat_pipe #(
    .DEPTH (RD_LAT)
  ) u_en_pipe (
    .clk (clk),
    .rst (rst),
    .d   (addr_vld),
    .q   (mac_en)
  );

  assign coeff_addr = {band_id, tap_idx};
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_eq_fir_scheduler.sv
// Directed bench for eq_fir_scheduler with 8 taps and 2-cycle read latency.
// Ports: none; drives the DUT and prints a CHECKS/ERRORS summary.
module tb_eq_fir_scheduler;
  import eq_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid;
  logic             lo_full;
  logic             hi_full;
  logic [TAP_W-1:0] tap_idx;
  logic [CA_W-1:0]  coeff_addr;
  logic             addr_vld;
  logic             buf_sel;
  logic             mac_clr;
  logic             mac_en;
  logic             band_done;
  logic [2:0]       band_id;
  logic             frame_done;
  logic             busy;
  logic             overrun;
  logic             amp_on;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  eq_fir_scheduler #(
    .N_TAPS (8),
    .RD_LAT (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .lo_full    (lo_full),
    .hi_full    (hi_full),
    .tap_idx    (tap_idx),
    .coeff_addr (coeff_addr),
    .addr_vld   (addr_vld),
    .buf_sel    (buf_sel),
    .mac_clr    (mac_clr),
    .mac_en     (mac_en),
    .band_done  (band_done),
    .band_id    (band_id),
    .frame_done (frame_done),
    .busy       (busy),
    .overrun    (overrun),
    .amp_on     (amp_on)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] act_ctrl();
    return {mac_clr, addr_vld, mac_en, band_done,
            frame_done, busy, amp_on, buf_sel,
            overrun, band_id};
  endfunction

  function automatic logic [11:0] exp_ctrl(input int c,
                                           input bit amp0,
                                           input int inj);
    int p, b;
    logic clr, av, me, bd, fd, amp, bs, ovr;
    p   = (c - 1) % 12;
    b   = (c - 1) / 12;
    clr = (p == 0);
    av  = (p >= 1 && p <= 8);
    me  = (p >= 3 && p <= 10);
    bd  = (p == 11);
    fd  = (c == 60);
    amp = (c == 60) ? 1'b1 : amp0;
    bs  = (b >= 3);
    ovr = (inj > 0 && inj < 60 && c > inj);
    return {clr, av, me, bd, fd, 1'b1, amp, bs, ovr, 3'(b)};
  endfunction

  // Caller raises valid in cycle 0; inj raises valid again in that cycle.
  task automatic frame_check(input bit amp0, input int inj);
    int p, b;
    logic [12:0] ea;
    for (int c = 1; c <= 60; c++) begin
      step();
      valid = 1'b0;
      check($sformatf("ctrl c%0d", c), 32'(act_ctrl()),
            32'(exp_ctrl(c, amp0, inj)));
      p = (c - 1) % 12;
      b = (c - 1) / 12;
      if (p >= 1 && p <= 8) begin
        ea = {3'(b), 10'(p - 1)};
        check($sformatf("addr c%0d", c), 32'(coeff_addr), 32'(ea));
      end
      if (c == inj) valid = 1'b1;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    valid   = 1'b0;
    lo_full = 1'b0;
    hi_full = 1'b0;
    do_reset(3);
    check("reset", {19'(act_ctrl()), coeff_addr},
          32'd0);

    lo_full = 1'b1;
    valid   = 1'b1;
    step();
    valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("noprime %0d", i),
            {29'd0, busy, addr_vld, overrun}, 32'd0);
      step();
    end

    hi_full = 1'b1;
    valid   = 1'b1;
    frame_check(1'b0, 0);
    step();
    check("idle after", {29'd0, busy, amp_on, overrun},
          32'b010);

    lo_full = 1'b0;
    step();
    check("amp drop", 32'(amp_on), 32'd0);
    lo_full = 1'b1;
    step();
    check("amp stays", 32'(amp_on), 32'd0);

    valid = 1'b1;
    frame_check(1'b0, 30);
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("ovr idle %0d", i),
            {29'd0, busy, overrun, mac_clr}, 32'b010);
    end

    do_reset(2);
    check("reset2", {20'(act_ctrl())}, 32'd0);
    valid = 1'b1;
    frame_check(1'b0, 60);
    frame_check(1'b1, 0);
    step();
    check("b2b idle", {29'd0, busy, overrun, amp_on},
          32'b001);

    valid = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      valid = 1'b0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst", {19'(act_ctrl()), coeff_addr},
          32'd0);
    for (int i = 0; i < 15; i++) begin
      step();
      check($sformatf("postrst %0d", i),
            {29'd0, band_done, busy, mac_en}, 32'd0);
    end

    valid = 1'b1;
    frame_check(1'b0, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eq_fir_scheduler.md
Name: eq_fir_scheduler

Overview:
Time-multiplexes one shared MAC engine across the five equalizer bands (LP, B1, B2, B3, HP) for both stereo channels. The two channels run in lock-step through the MAC lanes.
- Each new sample pair starts a frame once both circular buffers are primed.
- Per band, the block issues tap and coefficient addresses, and controls clear/accumulate of the MAC.
- It flags each band result for the band_scale/summing stage.
- It sits between the circular buffers/coefficient ROM and the MAC/band_scale datapath.

Parameters:
N_TAPS, 1021, taps per band FIR.
N_BANDS, 5, number of bands sequenced per frame.
RD_LAT, 2, cycles from address issue to data valid at MAC inputs (buffer + ROM read latency).
HI_MASK, 5'b11000, bit b set means band b reads the high (1536) buffer; clear means the low (1024) buffer.
TAP_W, 10, tap index width (2**TAP_W >= N_TAPS).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
valid  in  1  new sample pair written to buffers (1-cycle pulse)
lo_full  in  1  low-band circular buffer primed
hi_full  in  1  high-band circular buffer primed
tap_idx  out  TAP_W  buffer read offset for current tap
coeff_addr  out  3+TAP_W  {band_id, tap_idx} coefficient ROM address
addr_vld  out  1  tap_idx/coeff_addr valid this cycle
buf_sel  out  1  0 = low buffer, 1 = high buffer (from HI_MASK[band])
mac_clr  out  1  zero both MAC accumulators
mac_en  out  1  accumulate (addr_vld delayed RD_LAT cycles)
band_done  out  1  1-cycle pulse: accumulators hold final result for band_id
band_id  out  3  current band, 0..N_BANDS-1
frame_done  out  1  1-cycle pulse with band_done of last band
busy  out  1  high in any state but IDLE
overrun  out  1  sticky: valid arrived while a frame was still running
amp_on  out  1  amplifier enable

Behaviour:
- The reset is synchronous; every output and all internal state go to 0 when rst is high.
  - This includes the mac_en delay line.
  - The state returns to IDLE, and band_id, tap counter and overrun clear.
  - Reset mid-frame abandons the frame; no band_done is issued.
- FSM states: IDLE, CLR, RUN, DRAIN, NEXT.
  - IDLE: on valid & lo_full & hi_full, go to CLR with band_id = 0. Valid without both full is ignored; no overrun.
  - CLR (1 cycle): mac_clr = 1; tap counter = 0; go to RUN.
  - RUN (N_TAPS cycles): addr_vld = 1; tap_idx = counter, incremented each cycle. When tap_idx == N_TAPS-1, go to DRAIN. The counter does not wrap within a band.
  - DRAIN (RD_LAT cycles): addr_vld = 0; waits for delayed mac_en to finish.
  - NEXT (1 cycle): band_done = 1.
    - If band_id == N_BANDS-1: frame_done = 1 and go to IDLE, or directly to CLR with band_id = 0 if valid & lo_full & hi_full in this cycle. That valid is accepted, not counted as overrun.
    - Otherwise band_id++ and go to CLR.
- mac_en(t) = addr_vld(t-RD_LAT); this is an exact shift register. The last mac_en cycle is the final DRAIN cycle.
- coeff_addr = {band_id, tap_idx}. buf_sel = HI_MASK[band_id] and is held constant for the whole band.
- Timing:
  - Cycles per band: N_TAPS + RD_LAT + 2.
  - Frame: N_BANDS times that. With defaults this is 5125 cycles, and valid must be spaced at least that far apart.
- valid in any state other than IDLE, or other than the last-band NEXT case above: overrun <= 1 (sticky). The sample is dropped and the running frame continues unaffected.
- amp_on:
  - Set on the first frame_done.
  - Cleared when lo_full or hi_full falls. If this happens mid-frame, the frame completes normally, but amp_on stays 0 until the next frame_done that occurs while both are full.
- lo_full/hi_full are sampled only at frame start.

Decomposition:
- Package eq_pkg holds:
  - band enum (BAND_LP = 0, BAND_B1, BAND_B2, BAND_B3, BAND_HP)
  - N_BANDS, TAP_W and the coeff_addr width
  - FSM state typedef
  - default HI_MASK
- One sub-module: eq_lat_pipe, a parameterised RD_LAT-deep 1-bit shift register with synchronous reset, used for mac_en.

Test Plan:
All scenarios use N_TAPS = 8 and RD_LAT = 2 (12 cycles/band, 60 cycles/frame).
- Nominal frame: lo_full = hi_full = 1, one valid pulse. Required response:
  - mac_clr at cycles 1, 13, 25, 37, 49.
  - addr_vld for 8 cycles after each clear; mac_en is the same pattern shifted by 2 cycles.
  - band_done at cycles 12, 24, 36, 48, 60 with band_id 0–4.
  - frame_done and amp_on rise at cycle 60.
- Address/buffer map: coeff_addr runs 0x000..0x007 for band 0 and 0x400..0x407 for band 1; buf_sel = 0 for bands 0–2 and 1 for bands 3–4.
- Not primed: valid with hi_full = 0 -> busy, addr_vld and overrun all stay 0.
- Overrun: second valid at cycle 30 -> overrun = 1 and stays 1. The frame completes with frame_done at cycle 60, and no second frame starts.
- Back-to-back: second valid coincident with frame_done -> mac_clr the next cycle with band_id = 0, overrun = 0.
- Reset mid-frame: rst at cycle 20 for 1 cycle -> next cycle all outputs are 0 and no band_done follows. The next valid starts a clean frame.
